// File: rtl/jt49_nch_pkg.sv
// jt49_nch_pkg: shared constants for the jt49_nch sound generator.
// Holds the register offsets, envelope shape bit positions, the envelope
// FSM state encodings, the LFSR reset value and the log-to-linear table.
package jt49_nch_pkg;

  // Per-channel register offsets (address bits [1:0] within a channel block)
  localparam logic [1:0] REG_PER_LO = 2'd0;
  localparam logic [1:0] REG_PER_HI = 2'd1;
  localparam logic [1:0] REG_LVL    = 2'd2;
  localparam logic [1:0] REG_DIS    = 2'd3;

  // Global register offsets (address bits [1:0] within the global block)
  localparam logic [1:0] REG_NOISE  = 2'd0;
  localparam logic [1:0] REG_ENV_LO = 2'd1;
  localparam logic [1:0] REG_ENV_HI = 2'd2;
  localparam logic [1:0] REG_SHAPE  = 2'd3;

  // Envelope shape bit positions
  localparam int SHAPE_CONT = 3;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_HOLD = 0;

  // Envelope FSM states
  localparam logic ENV_RUN  = 1'b0;
  localparam logic ENV_HOLD = 1'b1;

  // Noise LFSR value after reset
  localparam logic [16:0] LFSR_RST = 17'h1;

  // 5-bit logarithmic level to 8-bit linear amplitude
  function automatic logic [7:0] log_to_lin(input logic [4:0] lvl);
    logic [7:0] lin;
    case (lvl)
      5'd0:  lin = 8'h00;  5'd1:  lin = 8'h01;  5'd2:  lin = 8'h01;  5'd3:  lin = 8'h02;
      5'd4:  lin = 8'h02;  5'd5:  lin = 8'h03;  5'd6:  lin = 8'h03;  5'd7:  lin = 8'h04;
      5'd8:  lin = 8'h06;  5'd9:  lin = 8'h07;  5'd10: lin = 8'h09;  5'd11: lin = 8'h0a;
      5'd12: lin = 8'h0c;  5'd13: lin = 8'h0e;  5'd14: lin = 8'h11;  5'd15: lin = 8'h13;
      5'd16: lin = 8'h17;  5'd17: lin = 8'h1b;  5'd18: lin = 8'h20;  5'd19: lin = 8'h25;
      5'd20: lin = 8'h2c;  5'd21: lin = 8'h35;  5'd22: lin = 8'h3e;  5'd23: lin = 8'h47;
      5'd24: lin = 8'h54;  5'd25: lin = 8'h66;  5'd26: lin = 8'h77;  5'd27: lin = 8'h88;
      5'd28: lin = 8'ha1;  5'd29: lin = 8'hc0;  5'd30: lin = 8'he0;  default: lin = 8'hff;
    endcase
    return lin;
  endfunction

endpackage

// File: rtl/jt49_nch_chan.sv
// jt49_nch_chan: one tone channel -- its four registers, the tone divider,
// the tone/noise gate, the level select and the registered linear output.
module jt49_nch_chan #(
  parameter int PERIOD_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cen8,
  input  logic       wr,
  input  logic [1:0] fld,
  input  logic [7:0] din,
  input  logic       noise,
  input  logic [4:0] env,
  output logic [7:0] rd_data,
  output logic [7:0] chan_out
);
  import jt49_nch_pkg::*;

  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic [4:0]          lvl_reg;     // {env_sel, vol[3:0]}
  logic [1:0]          dis_reg;     // {noise_dis, tone_dis}
  logic                tone_reg;
  logic [PERIOD_W:0]   count_inc;
  logic [PERIOD_W:0]   period_eff;
  logic                tone_wrap;
  logic                gate;
  logic [4:0]          lvl_next;

  // Register writes; bits outside the field width are never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg <= '0;
      lvl_reg    <= '0;
      dis_reg    <= '0;
    end else if (wr) begin
      case (fld)
        REG_PER_LO: period_reg[7:0] <= din;
        REG_PER_HI: period_reg      <= PERIOD_W'({din, period_reg[7:0]});
        REG_LVL:    lvl_reg         <= din[4:0];
        default:    dis_reg         <= din[1:0];
      endcase
    end
  end

  // Read-back of the addressed field with unused bits forced to zero
  always_comb begin
    rd_data = 8'd0;
    case (fld)
      REG_PER_LO: rd_data = period_reg[7:0];
      REG_PER_HI: rd_data = 8'(period_reg >> 8);
      REG_LVL:    rd_data = {3'd0, lvl_reg};
      default:    rd_data = {6'd0, dis_reg};
    endcase
  end

  // A period of zero behaves as one; the >= compare also catches a period
  // lowered below the running count, which then wraps on the next strobe.
  assign count_inc  = {1'b0, count_reg} + (PERIOD_W+1)'(1);
  assign period_eff = (period_reg == '0) ? (PERIOD_W+1)'(1) : {1'b0, period_reg};
  assign tone_wrap  = count_inc >= period_eff;

  // Tone divider: count on each base strobe, toggle the tone bit on wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      tone_reg  <= 1'b0;
    end else if (cen8) begin
      if (tone_wrap) begin
        count_reg <= '0;
        tone_reg  <= ~tone_reg;
      end else begin
        count_reg <= count_inc[PERIOD_W-1:0];
      end
    end
  end

  assign gate = (tone_reg | dis_reg[0]) & (noise | dis_reg[1]);

  // Level select: envelope or fixed volume (extended to 5 bits), muted by gate
  always_comb begin
    lvl_next = 5'd0;
    if (gate) lvl_next = lvl_reg[4] ? env : {lvl_reg[3:0], lvl_reg[3]};
  end

  // Linear output sampled on the input clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chan_out <= 8'd0;
    else if (clk_en) chan_out <= log_to_lin(lvl_next);
  end

endmodule

// File: rtl/jt49_nch.sv
// jt49_nch: multi-channel PSG-style tone generator with envelope and mixer.
// Optional noise generator enabled by defining JT49_NCH_NOISE_EN; without it
// noise reads as a constant 1 and the noise period register is absent.
module jt49_nch #(
  parameter  int CHANNELS = 3,
  parameter  int PERIOD_W = 12,
  localparam int AW       = $clog2(4*CHANNELS+4),
  localparam int SUM_W    = 8+$clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  sel,
  input  logic [AW-1:0]         addr,
  input  logic                  cs_n,
  input  logic                  wr_n,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [8*CHANNELS-1:0] chan_out,
  output logic [SUM_W-1:0]      sound
);
  import jt49_nch_pkg::*;

  logic [AW-3:0] blk;
  logic [1:0]    fld;
  logic          wr_en;
  logic          glb_sel;
  logic          glb_wr;
  logic [3:0]    pre_cnt_reg;
  logic          cen8;
  logic          noise;
  logic [15:0]   env_per_reg;
  logic [3:0]    shape_reg;
  logic [15:0]   env_cnt_reg;
  logic [16:0]   env_inc;
  logic [16:0]   env_per_eff;
  logic          env_tick;
  logic          env_restart;
  logic          env_state_reg;
  logic [4:0]    env_step_reg;
  logic          env_dir_reg;   // 1 = rising
  logic [4:0]    env_lvl;
  logic [7:0]    rd_ch [CHANNELS];
  logic [7:0]    rd_next;
  logic [SUM_W-1:0] sum_next;

  assign blk     = addr[AW-1:2];
  assign fld     = addr[1:0];
  assign wr_en   = !cs_n && !wr_n;
  assign glb_sel = blk == (AW-2)'(CHANNELS);
  assign glb_wr  = wr_en && glb_sel;

  // Base prescaler: eight clock enables per strobe, sixteen when sel is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pre_cnt_reg <= 4'd0;
    else if (clk_en) pre_cnt_reg <= pre_cnt_reg + 4'd1;
  end

  assign cen8 = clk_en && (sel ? (&pre_cnt_reg[2:0]) : (&pre_cnt_reg));

  // Global envelope registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_per_reg <= '0;
      shape_reg   <= '0;
    end else if (glb_wr) begin
      case (fld)
        REG_ENV_LO: env_per_reg[7:0]  <= din;
        REG_ENV_HI: env_per_reg[15:8] <= din;
        REG_SHAPE:  shape_reg         <= din[3:0];
        default: ;
      endcase
    end
  end

`ifdef JT49_NCH_NOISE_EN
  logic [4:0]  noise_per_reg;
  logic [4:0]  noise_cnt_reg;
  logic [16:0] lfsr_reg;
  logic [5:0]  noise_inc;
  logic [5:0]  noise_per_eff;

  // Noise period register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            noise_per_reg <= 5'd0;
    else if (glb_wr && fld == REG_NOISE)   noise_per_reg <= din[4:0];
  end

  assign noise_inc     = {1'b0, noise_cnt_reg} + 6'd1;
  assign noise_per_eff = (noise_per_reg == 5'd0) ? 6'd1 : {1'b0, noise_per_reg};

  // Noise divider and 17-bit LFSR (taps 17 and 14)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_cnt_reg <= 5'd0;
      lfsr_reg      <= LFSR_RST;
    end else if (cen8) begin
      if (noise_inc >= noise_per_eff) begin
        noise_cnt_reg <= 5'd0;
        lfsr_reg      <= {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[16:1]};
      end else begin
        noise_cnt_reg <= noise_inc[4:0];
      end
    end
  end

  assign noise = lfsr_reg[0];
`else
  assign noise = 1'b1;
`endif

  assign env_inc     = {1'b0, env_cnt_reg} + 17'd1;
  assign env_per_eff = (env_per_reg == 16'd0) ? 17'd1 : {1'b0, env_per_reg};
  assign env_tick    = cen8 && (env_inc >= env_per_eff);
  assign env_restart = glb_wr && fld == REG_SHAPE;

  // Envelope divider, cleared by a shape write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           env_cnt_reg <= 16'd0;
    else if (env_restart) env_cnt_reg <= 16'd0;
    else if (cen8)        env_cnt_reg <= (env_inc >= env_per_eff) ? 16'd0 : env_inc[15:0];
  end

  // Envelope FSM. Held levels are encoded as step 31 (or 0) with a direction
  // so the output formula stays the same in both states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_state_reg <= ENV_HOLD;
      env_step_reg  <= 5'd0;
      env_dir_reg   <= 1'b1;
    end else if (env_restart) begin
      env_state_reg <= ENV_RUN;
      env_step_reg  <= 5'd0;
      env_dir_reg   <= din[SHAPE_ATT];
    end else if (env_tick && env_state_reg == ENV_RUN) begin
      if (env_step_reg == 5'd31) begin
        if (!shape_reg[SHAPE_CONT]) begin
          env_state_reg <= ENV_HOLD;
          env_step_reg  <= 5'd0;
          env_dir_reg   <= 1'b1;
        end else if (shape_reg[SHAPE_HOLD]) begin
          env_state_reg <= ENV_HOLD;
          env_dir_reg   <= shape_reg[SHAPE_ALT] ? ~env_dir_reg : env_dir_reg;
        end else if (shape_reg[SHAPE_ALT]) begin
          env_step_reg  <= 5'd0;
          env_dir_reg   <= ~env_dir_reg;
        end else begin
          env_step_reg  <= 5'd0;
        end
      end else begin
        env_step_reg <= env_step_reg + 5'd1;
      end
    end
  end

  assign env_lvl = env_dir_reg ? env_step_reg : ~env_step_reg;

  // Channel instances, each owning a 4-register block
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic ch_wr;
    assign ch_wr = wr_en && blk == (AW-2)'(gi);

    jt49_nch_chan #(.PERIOD_W(PERIOD_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_en   (clk_en),
      .cen8     (cen8),
      .wr       (ch_wr),
      .fld      (fld),
      .din      (din),
      .noise    (noise),
      .env      (env_lvl),
      .rd_data  (rd_ch[gi]),
      .chan_out (chan_out[8*gi +: 8])
    );
  end

  // Read mux across channel blocks and the global block; anything else is 0
  always_comb begin
    rd_next = 8'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (blk == (AW-2)'(c)) rd_next = rd_ch[c];
    end
    if (glb_sel) begin
      case (fld)
`ifdef JT49_NCH_NOISE_EN
        REG_NOISE:  rd_next = {3'd0, noise_per_reg};
`else
        REG_NOISE:  rd_next = 8'd0;
`endif
        REG_ENV_LO: rd_next = env_per_reg[7:0];
        REG_ENV_HI: rd_next = env_per_reg[15:8];
        default:    rd_next = {4'd0, shape_reg};
      endcase
    end
  end

  // Registered read data, loaded whenever the chip is selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dout <= 8'd0;
    else if (!cs_n) dout <= rd_next;
  end

  // Mixer: zero-extended sum of all channel outputs
  always_comb begin
    sum_next = '0;
    for (int c = 0; c < CHANNELS; c++) sum_next += SUM_W'(chan_out[8*c +: 8]);
  end

  // Mixed output sampled one clock enable after the channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sound <= '0;
    else if (clk_en) sound <= sum_next;
  end

endmodule
